// File: rtl/cluster_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : cluster_load_ctrl_pkg
// Brief  : Shared cluster parameters, GLB base addresses and the FSM
//          state encoding for the cluster load controller.
// Rev    : 1.0 - initial release
// ============================================================================
package cluster_load_ctrl_pkg;

    localparam int CLC_DATA_BITWIDTH = 16;
    localparam int CLC_ADDR_BITWIDTH = 10;
    localparam int CLC_W_BASE_ADDR   = 0;
    localparam int CLC_A_BASE_ADDR   = 100;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_W    = 3'd1,
        ST_LOAD_A    = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cluster_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module : cluster_load_ctrl
// Brief  : Accepts a job descriptor, streams weights then iacts into the
//          GLB, launches the PE cluster and waits for it to finish.
// Rev    : 1.0 - initial release
// ============================================================================
module cluster_load_ctrl
    import cluster_load_ctrl_pkg::*;
#(
    parameter int DATA_BITWIDTH = CLC_DATA_BITWIDTH,
    parameter int ADDR_BITWIDTH = CLC_ADDR_BITWIDTH,
    parameter int W_BASE_ADDR   = CLC_W_BASE_ADDR,
    parameter int A_BASE_ADDR   = CLC_A_BASE_ADDR
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [ADDR_BITWIDTH-1:0]        cfg_num_wght,
    input  logic [ADDR_BITWIDTH-1:0]        cfg_num_iact,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [DATA_BITWIDTH-1:0] in_data,
    output logic                            write_en_wght,
    output logic                            write_en_iact,
    output logic [ADDR_BITWIDTH-1:0]        w_addr_wght,
    output logic [ADDR_BITWIDTH-1:0]        w_addr_iact,
    output logic signed [DATA_BITWIDTH-1:0] w_data_wght,
    output logic signed [DATA_BITWIDTH-1:0] w_data_iact,
    output logic                            start,
    input  logic                            compute_done,
    output logic                            busy,
    output logic                            job_done
);

    localparam logic [ADDR_BITWIDTH-1:0] c_w_base = ADDR_BITWIDTH'(W_BASE_ADDR);
    localparam logic [ADDR_BITWIDTH-1:0] c_a_base = ADDR_BITWIDTH'(A_BASE_ADDR);
    localparam logic [ADDR_BITWIDTH-1:0] c_one    = ADDR_BITWIDTH'(1);
    localparam logic [ADDR_BITWIDTH-1:0] c_zero   = '0;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDR_BITWIDTH-1:0] r_cnt;       // beat index in LOAD_*, first-cycle flag in WAIT_DONE
    logic [ADDR_BITWIDTH-1:0] w_cnt_nxt;
    logic [ADDR_BITWIDTH-1:0] r_num_w;
    logic [ADDR_BITWIDTH-1:0] r_num_a;
    logic                     w_latch;
    logic                     w_we_w;
    logic                     w_we_a;

    assign busy = (r_state != ST_IDLE);

    // Next-state, handshake and pulse decode; ready outputs are held low during reset
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_we_w      = 1'b0;
        w_we_a      = 1'b0;
        cfg_ready   = 1'b0;
        in_ready    = 1'b0;
        start       = 1'b0;
        job_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_ready = reset;
                if (cfg_valid && reset) begin
                    w_latch   = 1'b1;
                    w_cnt_nxt = c_zero;
                    if (cfg_num_wght != c_zero)      w_state_nxt = ST_LOAD_W;
                    else if (cfg_num_iact != c_zero) w_state_nxt = ST_LOAD_A;
                    else                             w_state_nxt = ST_START;
                end
            end
            ST_LOAD_W: begin
                in_ready = reset;
                if (in_valid) begin
                    w_we_w = 1'b1;
                    if (r_cnt == r_num_w - c_one) begin
                        w_cnt_nxt   = c_zero;
                        w_state_nxt = (r_num_a != c_zero) ? ST_LOAD_A : ST_START;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
            end
            ST_LOAD_A: begin
                in_ready = reset;
                if (in_valid) begin
                    w_we_a = 1'b1;
                    if (r_cnt == r_num_a - c_one) begin
                        w_cnt_nxt   = c_zero;
                        w_state_nxt = ST_START;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
            end
            ST_START: begin
                // The final write strobe may still be on the bus; hold off one cycle
                if (!(write_en_wght || write_en_iact)) begin
                    start       = 1'b1;
                    w_cnt_nxt   = c_zero;
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // First cycle only arms; a stale compute_done level is not trusted
                if (r_cnt == c_zero)   w_cnt_nxt   = c_one;
                else if (compute_done) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                job_done    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, counters, latched job counts and registered GLB write port
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_num_w       <= '0;
            r_num_a       <= '0;
            write_en_wght <= 1'b0;
            write_en_iact <= 1'b0;
            w_addr_wght   <= '0;
            w_addr_iact   <= '0;
            w_data_wght   <= '0;
            w_data_iact   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            write_en_wght <= w_we_w;
            write_en_iact <= w_we_a;
            if (w_latch) begin
                r_num_w <= cfg_num_wght;
                r_num_a <= cfg_num_iact;
            end
            if (w_we_w) begin
                w_addr_wght <= c_w_base + r_cnt;
                w_data_wght <= in_data;
            end
            if (w_we_a) begin
                w_addr_iact <= c_a_base + r_cnt;
                w_data_iact <= in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cluster_load_ctrl.md
CLUSTER_LOAD_CTRL -- requirements
Module: cluster_load_ctrl

Interface
REQ-001 Parameter DATA_BITWIDTH, 16, data word width.
REQ-002 Parameter ADDR_BITWIDTH, 10, GLB address width.
REQ-003 Parameter W_BASE_ADDR, 0, first GLB weight write address.
REQ-004 Parameter A_BASE_ADDR, 100, first GLB iact write address.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 cfg_valid / cfg_ready  input / output  1 / 1  job-descriptor handshake.
REQ-008 cfg_num_wght, cfg_num_iact  input  ADDR_BITWIDTH each  word counts for the job.
REQ-009 in_valid / in_ready  input / output  1 / 1  data stream handshake.
REQ-010 in_data  input  DATA_BITWIDTH (signed)  stream word: weights first, then iacts.
REQ-011 write_en_wght, write_en_iact  output  1 each  GLB write strobes.
REQ-012 w_addr_wght, w_addr_iact  output  ADDR_BITWIDTH each  GLB write addresses.
REQ-013 w_data_wght, w_data_iact  output  DATA_BITWIDTH (signed) each  GLB write data.
REQ-014 start  output  1  one-cycle pulse that launches the PE cluster.
REQ-015 compute_done  input  1  level from the cluster; high when computation is finished.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 job_done  output  1  one-cycle pulse when a job completes.

Function
REQ-018 FSM states: IDLE, LOAD_W, LOAD_A, START, WAIT_DONE, DONE.
REQ-019 IDLE: cfg_ready=1; cfg_valid & cfg_ready latches both counts, clears the index counter and moves to LOAD_W.
REQ-020 LOAD_W: in_ready=1; each in_valid&in_ready beat writes one weight; after beat cfg_num_wght-1, move to LOAD_A.
REQ-021 LOAD_A: in_ready=1; each beat writes one iact; after beat cfg_num_iact-1, move to START.
REQ-022 A zero count skips its phase in the same transition (IDLE->LOAD_A, or LOAD_W/IDLE->START); 0/0 goes IDLE->START.
REQ-023 Write outputs are registered: the strobe, address and data appear exactly 1 cycle after the accepting handshake and the strobe lasts 1 cycle.
REQ-024 Beat k of a phase uses address BASE+k modulo 2^ADDR_BITWIDTH; the address wraps silently.
REQ-025 in_valid low stalls the phase with no write; in_ready is 0 outside LOAD_W/LOAD_A.
REQ-026 START: start=1 for exactly one cycle, then move to WAIT_DONE.
REQ-027 START is entered only after the final write strobe has been issued, so start is never coincident with or before the last write.
REQ-028 WAIT_DONE: ignore compute_done during the first cycle, then move to DONE on compute_done=1.
REQ-029 DONE: job_done=1 for one cycle, then move to IDLE; a new cfg is accepted no earlier than the following cycle.
REQ-030 cfg_valid outside IDLE is ignored and not queued.
REQ-031 Counts are held internally, so changes on cfg_num_* mid-job have no effect.

Reset
REQ-032 While reset=0 at a clock edge: state=IDLE, counters=0, write strobes=0, addresses=0, data=0, start=0, job_done=0, busy=0, in_ready=0, cfg_ready=0.
REQ-033 Reset asserted mid-job aborts immediately with no further write strobes; cfg_ready=1 on the first cycle after reset is released.

Structure
REQ-034 The FSM state encoding and the base-address defaults belong in a shared package with the cluster parameters.
REQ-035 The block is a single module with no sub-modules; one ADDR_BITWIDTH index counter is shared by both phases.

Verification
REQ-036 cfg 9/25, in_valid held high -> 9 weight writes at addresses 0..8, then 25 iact writes at 100..124, start pulse 1 cycle after the last write, job_done 1 cycle after compute_done.
REQ-037 cfg 9/25, in_valid toggling every other cycle -> same address/data sequence, no write on idle cycles, in_ready stays high.
REQ-038 cfg 0/4 -> no weight writes, iact writes at 100..103; cfg 0/0 -> start 1 cycle after cfg accept.
REQ-039 With A_BASE_ADDR=1022, cfg 0/4 -> iact addresses 1022, 1023, 0, 1.
REQ-040 reset low during beat 5 of LOAD_A -> no strobes after reset, busy=0; a new cfg 1/1 then completes normally.
REQ-041 compute_done held high before start -> job_done not earlier than 2 cycles after the start pulse; cfg_valid during LOAD_W is ignored.
